// File: rtl/prim_dom_mul_ctrl_pkg.sv
// Shared types for the DOM AND sequencing front-end.
// The sequencer walks through IDLE -> RND -> MUL0 -> MUL1 -> OUT, and the
// encoding is fixed so that state values stay stable across builds.
package prim_dom_mul_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RND  = 3'd1,
    MUL0 = 3'd2,
    MUL1 = 3'd3,
    OUT  = 3'd4
  } state_e;

endpackage

// File: rtl/prim_dom_and_2share.sv
// First-order (2-share) Domain-Oriented Masking AND gadget.
// The inner-domain terms a0&b0 and a1&b1 are combinational. The cross-domain
// terms are blinded with c0/c1 and then registered. With c0 == c1 the two
// output shares recombine to (a0^a1) & (b0^b1). EnNegedge moves the
// cross-term register to the falling clock edge.
module prim_dom_and_2share #(
  parameter int DW        = 32,
  parameter bit EnNegedge = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  input  logic [DW-1:0] c0_i,
  input  logic [DW-1:0] c1_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o
);

  logic [DW-1:0] cross0_d, cross1_d;
  logic [DW-1:0] cross0_q, cross1_q;

  assign cross0_d = (a0_i & b1_i) ^ c0_i;
  assign cross1_d = (a1_i & b0_i) ^ c1_i;

  generate
    if (EnNegedge) begin : g_neg
      // Register the blinded cross terms on the falling edge
      always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cross0_q <= '0;
          cross1_q <= '0;
        end else begin
          cross0_q <= cross0_d;
          cross1_q <= cross1_d;
        end
      end
    end else begin : g_pos
      // Register the blinded cross terms on the rising edge
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cross0_q <= '0;
          cross1_q <= '0;
        end else begin
          cross0_q <= cross0_d;
          cross1_q <= cross1_d;
        end
      end
    end
  endgenerate

  assign q0_o = (a0_i & b0_i) ^ cross0_q;
  assign q1_o = (a1_i & b1_i) ^ cross1_q;

endmodule

// File: rtl/prim_dom_mul_ctrl.sv
// Sequencing front-end for a 2-share DOM AND gadget.
// Operand shares are accepted over valid/ready and one fresh mask word is
// fetched over req/ack. The gadget is then driven from stable registers for
// two cycles, and the output shares are returned over valid/ready.
// Optional build macro PRIM_DOM_MUL_CTRL_CLR_EN: clears the operand and mask
// registers on result handoff, and clears the result registers one cycle later.
module prim_dom_mul_ctrl
  import prim_dom_mul_ctrl_pkg::*;
#(
  parameter int DW        = 32,
  parameter bit EnNegedge = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  output logic          rnd_req_o,
  input  logic          rnd_ack_i,
  input  logic [DW-1:0] rnd_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o,
  output logic          busy_o
);

  state_e state_q, state_d;

  logic [DW-1:0] a0_q, a1_q, b0_q, b1_q, z_q;
  logic [DW-1:0] q0_q, q1_q;
  logic [DW-1:0] g_q0, g_q1;
  logic          accept, rnd_take, handoff;

  assign accept   = (state_q == IDLE) && in_valid_i;
  assign rnd_take = (state_q == RND) && rnd_ack_i;
  assign handoff  = (state_q == OUT) && out_ready_i;

  // Hold the current sequencer state; reset returns to IDLE immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Advance through the fixed operation sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = RND;
      RND:     if (rnd_ack_i)   state_d = MUL0;
      MUL0:                     state_d = MUL1;
      MUL1:                     state_d = OUT;
      OUT:     if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Handshake outputs come from the registered state only
  always_comb begin
    in_ready_o  = 1'b0;
    rnd_req_o   = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      RND:     rnd_req_o   = 1'b1;
      OUT:     out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Capture operand shares on accept so the gadget sees stable inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
    end else if (accept) begin
      a0_q <= a0_i;
      a1_q <= a1_i;
      b0_q <= b0_i;
      b1_q <= b1_i;
`ifdef PRIM_DOM_MUL_CTRL_CLR_EN
    end else if (handoff) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
`endif
    end
  end

  // Capture the fresh mask word on the randomness handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      z_q <= '0;
    end else if (rnd_take) begin
      z_q <= rnd_i;
`ifdef PRIM_DOM_MUL_CTRL_CLR_EN
    end else if (handoff) begin
      z_q <= '0;
`endif
    end
  end

  // Both share domains must be blinded with the same z for correct recombination
  prim_dom_and_2share #(
    .DW       (DW),
    .EnNegedge(EnNegedge)
  ) u_and (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .a0_i  (a0_q),
    .a1_i  (a1_q),
    .b0_i  (b0_q),
    .b1_i  (b1_q),
    .c0_i  (z_q),
    .c1_i  (z_q),
    .q0_o  (g_q0),
    .q1_o  (g_q1)
  );

`ifdef PRIM_DOM_MUL_CTRL_CLR_EN
  logic clr_q;

  // Delay the handoff pulse so the result shares clear one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) clr_q <= 1'b0;
    else         clr_q <= handoff;
  end

  // Latch gadget outputs at the end of MUL1, then scrub them after handoff
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q0_q <= '0;
      q1_q <= '0;
    end else if (state_q == MUL1) begin
      q0_q <= g_q0;
      q1_q <= g_q1;
    end else if (clr_q) begin
      q0_q <= '0;
      q1_q <= '0;
    end
  end
`else
  // Latch gadget outputs at the end of MUL1 and hold them until the next result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q0_q <= '0;
      q1_q <= '0;
    end else if (state_q == MUL1) begin
      q0_q <= g_q0;
      q1_q <= g_q1;
    end
  end
`endif

  assign q0_o = q0_q;
  assign q1_o = q1_q;

endmodule
